// File: rtl/gs232c_inst_queue_rd_pkg.sv
// gs232c_inst_queue_rd_pkg: instruction-queue defaults and d_take encoding shared with the writer
package gs232c_inst_queue_rd_pkg;
  localparam int iq_w = 39;
  localparam int iq_n = 2;
  localparam int iq_m = 3;
  typedef logic [1:0] take_t;
  function automatic int min_int(input int a, input int b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/gs232c_inst_queue_rd_if.sv
// gs232c_inst_queue_rd_if: queue-read / decode-issue bus
// master drives cancel, tail, q_data, d_take; slave (reader) drives head, d_valid, d_data, empty
interface gs232c_inst_queue_rd_if
  import gs232c_inst_queue_rd_pkg::*;
#(
  parameter int w = iq_w,
  parameter int n = iq_n,
  parameter int m = iq_m
);
  logic cancel;
  logic [n+2:0] tail;
  logic [n+2:0] head;
  logic [w*m-1:0] q_data;
  logic [m-1:0] d_valid;
  logic [w*m-1:0] d_data;
  take_t d_take;
  logic empty;
  modport master (output cancel, tail, q_data, d_take, input head, d_valid, d_data, empty);
  modport slave (input cancel, tail, q_data, d_take, output head, d_valid, d_data, empty);
endinterface

// File: rtl/gs232c_iq_compact.sv
// gs232c_iq_compact: shifts surviving issue slots down by take and appends load entries from q_data
// in: slots, valid, take, q_data, load; out: next_slots, next_valid
module gs232c_iq_compact
  import gs232c_inst_queue_rd_pkg::*;
#(
  parameter int w = iq_w,
  parameter int m = iq_m
) (
  input  logic [w*m-1:0] slots,
  input  logic [m-1:0]   valid,
  input  take_t          take,
  input  logic [w*m-1:0] q_data,
  input  logic [1:0]     load,
  output logic [w*m-1:0] next_slots,
  output logic [m-1:0]   next_valid
);
  int left;
  int fill;
  always_comb begin
    left = $countones(valid) - int'(take);
    fill = left + int'(load);
    next_slots = slots;
    next_valid = '0;
    for (int k = 0; k < m; k++) begin
      next_valid[k] = k < fill;
      if (k < left) next_slots[k*w +: w] = slots[(k + int'(take))*w +: w];
      else if (k < fill) next_slots[k*w +: w] = q_data[(k - left)*w +: w];
    end
  end
endmodule

// File: rtl/gs232c_inst_queue_rd.sv
// gs232c_inst_queue_rd: instruction-queue reader feeding up to m decode slots per cycle
// in: clock, reset (async), bus.cancel, bus.tail, bus.q_data, bus.d_take
// out: bus.head, bus.d_valid, bus.d_data, bus.empty
module gs232c_inst_queue_rd
  import gs232c_inst_queue_rd_pkg::*;
#(
  parameter int w = iq_w,
  parameter int n = iq_n,
  parameter int m = iq_m
) (
  input logic clock,
  input logic reset,
  gs232c_inst_queue_rd_if.slave bus
);
  logic [n+2:0] avail;
  logic [1:0] load;
  logic [w*m-1:0] next_slots;
  logic [m-1:0] next_valid;
  int room;
  always_comb begin
    avail = bus.tail - bus.head;
    room = m - ($countones(bus.d_valid) - int'(bus.d_take));
    load = bus.cancel ? 2'd0 : 2'(min_int(int'(avail), room));
  end
  assign bus.empty = bus.tail == bus.head && bus.d_valid == '0;
  gs232c_iq_compact #(.w(w), .m(m)) u_compact (
    .slots(bus.d_data),
    .valid(bus.d_valid),
    .take(bus.d_take),
    .q_data(bus.q_data),
    .load(load),
    .next_slots(next_slots),
    .next_valid(next_valid)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bus.head <= '0;
      bus.d_valid <= '0;
    end else begin
      bus.head <= bus.head + {{(n+1){1'b0}}, load};
      bus.d_valid <= bus.cancel ? '0 : next_valid;
    end
  // slot payload carries no reset; only d_valid qualifies it
  always_ff @(posedge clock)
    bus.d_data <= next_slots;
endmodule

// File: tb/tb_gs232c_inst_queue_rd.sv
// tb_gs232c_inst_queue_rd: reader paired with a queue-writer model, checked against a FIFO reference
module tb_gs232c_inst_queue_rd;
  import gs232c_inst_queue_rd_pkg::*;
  localparam int W = 39, N = 2, M = 3, D = 4 << N, P = 1 << (N + 3);
  logic clock = 0;
  logic reset = 1;
  logic push;
  logic [W-1:0] push_data;
  logic [W-1:0] mem [D];
  logic [W-1:0] mq [$];
  logic [W-1:0] ms [$];
  int mhead;
  int checks = 0;
  int errors = 0;
  gs232c_inst_queue_rd_if #(.w(W), .n(N), .m(M)) bus ();
  gs232c_inst_queue_rd #(.w(W), .n(N), .m(M)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always_ff @(posedge clock or posedge reset)
    if (reset) bus.tail <= '0;
    else if (bus.cancel) bus.tail <= bus.head;
    else if (push) bus.tail <= bus.tail + 1'b1;
  always @(posedge clock)
    if (!reset && !bus.cancel && push) mem[bus.tail[N+1:0]] <= push_data;
  for (genvar g = 0; g < M; g++) begin : g_rd
    logic [N+2:0] a;
    assign a = bus.head + (N+3)'(g);
    assign bus.q_data[g*W +: W] = mem[a[N+1:0]];
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic compare();
    check("d_valid", 64'(bus.d_valid), 64'((1 << ms.size()) - 1));
    check("head", 64'(bus.head), 64'(mhead));
    check("empty", 64'(bus.empty), 64'(mq.size() == 0 && ms.size() == 0));
    for (int k = 0; k < ms.size(); k++) check("slot", 64'(bus.d_data[k*W +: W]), 64'(ms[k]));
  endtask
  task automatic step(input int tk, input bit ps, input bit cn);
    int ld;
    bit pushed;
    check("take_legal", 64'(tk <= $countones(bus.d_valid)), 64'(1));
    pushed = ps && mq.size() < D && !cn;
    push = pushed;
    push_data = W'({$urandom, $urandom});
    bus.d_take = 2'(tk);
    bus.cancel = cn;
    @(posedge clock);
    if (cn) begin
      mq.delete();
      ms.delete();
    end else begin
      for (int i = 0; i < tk; i++) ms.delete(0);
      ld = M - ms.size();
      if (mq.size() < ld) ld = mq.size();
      for (int i = 0; i < ld; i++) ms.push_back(mq.pop_front());
      mhead = (mhead + ld) % P;
      if (pushed) mq.push_back(push_data);
    end
    #1;
    push = 0;
    bus.d_take = '0;
    bus.cancel = 0;
    compare();
  endtask
  task automatic drain_all();
    for (int g = 0; g < 60 && (ms.size() > 0 || mq.size() > 0); g++) step(ms.size(), 0, 0);
    check("drain_empty", 64'(bus.empty), 64'(1));
  endtask
  task automatic async_reset();
    #2 reset = 1;
    #1;
    check("arst_head", 64'(bus.head), 64'(0));
    check("arst_valid", 64'(bus.d_valid), 64'(0));
    mq.delete();
    ms.delete();
    mhead = 0;
    @(negedge clock) reset = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    int h;
    push = 0;
    push_data = '0;
    bus.cancel = 0;
    bus.d_take = '0;
    mhead = 0;
    #12;
    check("rst_head", 64'(bus.head), 64'(0));
    check("rst_valid", 64'(bus.d_valid), 64'(0));
    @(negedge clock) reset = 0;
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    check("a_valid", 64'(bus.d_valid), 64'(3'b111));
    check("a_head", 64'(bus.head), 64'(3));
    step(0, 0, 0);
    check("a_hold_valid", 64'(bus.d_valid), 64'(3'b111));
    check("a_hold_head", 64'(bus.head), 64'(3));
    step(2, 0, 0);
    check("a_take_valid", 64'(bus.d_valid), 64'(3'b011));
    check("a_take_head", 64'(bus.head), 64'(4));
    check("a_take_empty", 64'(bus.empty), 64'(0));
    drain_all();
    for (int g = 0; g < 40 && mhead < 13; g++) step(ms.size(), 1, 0);
    drain_all();
    for (int g = 0; g < 40 && mq.size() < D; g++) step(0, 1, 0);
    drain_all();
    for (int g = 0; g < 40 && ms.size() + mq.size() < 8; g++) step(0, 1, 0);
    h = mhead;
    step(1, 0, 1);
    check("cancel_valid", 64'(bus.d_valid), 64'(0));
    check("cancel_head", 64'(bus.head), 64'(h));
    check("cancel_tail", 64'(bus.tail), 64'(bus.head));
    check("cancel_empty", 64'(bus.empty), 64'(1));
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    step(1, 0, 0);
    async_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    check("post_rst_valid", 64'(bus.d_valid), 64'(0));
    step(0, 1, 0);
    step(0, 0, 0);
    check("post_rst_push", 64'(bus.d_valid), 64'(3'b001));
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) async_reset();
      step(int'($urandom_range(ms.size(), 0)), $urandom_range(3, 0) != 0, $urandom_range(31, 0) == 0);
    end
    drain_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
